// File: rtl/ram_cmd_bridge_pkg.sv
// ram_bridge_pkg: shared types and constants for the RAM command bridge
package ram_bridge_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int TIMEOUT_DEF = 16;
  localparam int TMR_W = $clog2(TIMEOUT_DEF);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;
endpackage

// File: rtl/ram_cmd_bridge_if.sv
// ram_cmd_bridge_if: host request/response and RAM handshake signals
interface ram_cmd_bridge_if
  import ram_bridge_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
);
  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid, rsp_ready, rsp_wr, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_data;
  logic          en, wr_rd, valid, ready, error;
  logic [AW-1:0] addr;
  logic [DW-1:0] din, dout;
  modport master (
    input  req_valid, req_wr, req_addr, req_data, rsp_ready, dout, ready, error,
    output req_ready, rsp_valid, rsp_wr, rsp_data, rsp_err, rsp_timeout, en, wr_rd, addr, din, valid
  );
  modport slave (
    output req_valid, req_wr, req_addr, req_data, rsp_ready, dout, ready, error,
    input  req_ready, rsp_valid, rsp_wr, rsp_data, rsp_err, rsp_timeout, en, wr_rd, addr, din, valid
  );
endinterface

// File: rtl/ram_req_fifo.sv
// ram_req_fifo: synchronous request FIFO; a push while full is refused even with a concurrent pop
module ram_req_fifo
  import ram_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  req_t                     din_i,
  output req_t                     dout_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  req_t          mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;
  assign do_push = push_i && cnt_q != CW'(DEPTH);
  assign do_pop  = pop_i && cnt_q != '0;
  assign dout_o  = mem_q[rd_q];
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + PW'(do_push);
      rd_q  <= rd_q + PW'(do_pop);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  // entry storage
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/ram_cmd_bridge.sv
// ram_cmd_bridge: queues host requests and issues them one at a time to the RAM with a timeout
module ram_cmd_bridge
  import ram_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  ram_cmd_bridge_if.master bus,
  output logic [7:0]       err_count
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = (TIMEOUT == TIMEOUT_DEF) ? TMR_W : $clog2(TIMEOUT);
  state_t                state_q, state_d;
  req_t                  head, push_req;
  logic                  empty, pop, done, tout, fin;
  logic [CW-1:0]         cnt;
  logic                  en_q, en_d, wr_q, wr_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_wr_q, rsp_wr_d;
  logic                  rsp_err_q, rsp_err_d, rsp_to_q, rsp_to_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d, rsp_data_q, rsp_data_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [7:0]            err_q, err_d;
  assign push_req      = '{wr: bus.req_wr, addr: bus.req_addr, data: bus.req_data};
  assign bus.req_ready = cnt < CW'(FIFO_DEPTH);
  ram_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.req_valid && bus.req_ready),
    .pop_i   (pop),
    .din_i   (push_req),
    .dout_o  (head),
    .empty_o (empty),
    .count_o (cnt)
  );
  // the first ISSUE cycle only raises en; ready counts once en is visible to the RAM
  assign pop  = state_q == IDLE && !empty;
  assign done = state_q == ISSUE && en_q && bus.ready;
  assign tout = state_q == ISSUE && en_q && !bus.ready && tmr_q == TW'(TIMEOUT - 1);
  assign fin  = done || tout;
  // state register
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
  end
  // next-state: fetch, wait for completion or timeout, hold response until accepted
  always_comb begin
    state_d = pop ? ISSUE : fin ? RESP : (state_q == RESP && rsp_valid_q && bus.rsp_ready) ? IDLE : state_q;
  end
  // next values of the registered RAM-side and response outputs
  always_comb begin
    en_d        = state_q == ISSUE && !fin;
    tmr_d       = (state_q == ISSUE && en_q) ? tmr_q + TW'(1) : '0;
    wr_d        = pop ? head.wr : wr_q;
    addr_d      = pop ? head.addr : addr_q;
    din_d       = pop ? head.data : din_q;
    rsp_valid_d = state_q == RESP && !(rsp_valid_q && bus.rsp_ready);
    rsp_wr_d    = fin ? wr_q : rsp_wr_q;
    rsp_data_d  = fin ? ((done && !wr_q) ? bus.dout : '0) : rsp_data_q;
    rsp_err_d   = fin ? (tout || bus.error) : rsp_err_q;
    rsp_to_d    = fin ? tout : rsp_to_q;
    err_d       = (fin && rsp_err_d && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end
  // output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q        <= 1'b0;
      tmr_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      err_q       <= '0;
    end else begin
      en_q        <= en_d;
      tmr_q       <= tmr_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
      err_q       <= err_d;
    end
  end
  assign bus.en          = en_q;
  assign bus.valid       = en_q;
  assign bus.wr_rd       = wr_q;
  assign bus.addr        = addr_q;
  assign bus.din         = din_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_wr      = rsp_wr_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_to_q;
  assign err_count       = err_q;
endmodule
